// File: rtl/deconv_overlap_add.sv
// Overlap-adds deconv product beats into a ring of K column accumulators; drains finished columns.
// Latency: last beat of an input column -> first o_col_valid next cycle. Optional DECONV_OVL_RELU_EN clamps outputs.
module deconv_overlap_add #(
    parameter int  BIT_WIDTH            = 8,
    parameter int  NO_COL_KERNEL        = 5,
    parameter int  NO_COL_INPUT_FEATURE = 8,
    parameter int  STRIDE               = 2,
    parameter int  ACC_W                = 2*BIT_WIDTH+4,
    localparam int L = (NO_COL_INPUT_FEATURE-1)*STRIDE + NO_COL_KERNEL
) (
    input  logic                                                    i_clk,
    input  logic                                                    i_rst_n,
    input  logic                                                    i_valid,
    output logic                                                    o_ready,
    input  logic [2*BIT_WIDTH*NO_COL_KERNEL*NO_COL_INPUT_FEATURE-1:0] i_prod_col,
    output logic                                                    o_col_valid,
    input  logic                                                    i_col_ready,
    output logic [ACC_W*L-1:0]                                      o_col,
    output logic [7:0]                                              o_col_idx,
    output logic                                                    o_last_col,
    output logic                                                    o_chnl_done
);
    localparam int K  = NO_COL_KERNEL;
    localparam int N  = NO_COL_INPUT_FEATURE;
    localparam int S  = STRIDE;
    localparam int PW = 2*BIT_WIDTH;
    localparam int KW = $clog2(K) + 1;
    localparam int NW = $clog2(N) + 1;

    localparam logic [KW-1:0] KC_LAST = KW'(K-1);
    localparam logic [KW-1:0] S_LAST  = KW'(S-1);
    localparam logic [KW:0]   K_SUM   = (KW+1)'(K);
    localparam logic [NW-1:0] IC_LAST = NW'(N-1);
    localparam logic [7:0]    X_LAST  = 8'(L-1);

    typedef enum logic [0:0] {ACCUM, DRAIN} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_live;
    logic [KW-1:0]            r_kc;
    logic [NW-1:0]            r_ic;
    logic [7:0]               r_x;
    logic [KW-1:0]            r_x_slot;
    logic [KW-1:0]            r_e;
    logic                     r_done;
    logic signed [ACC_W-1:0]  r_ring [K][L];

    logic                     w_acc;
    logic                     w_hs;
    logic                     w_e_last;
    logic                     w_last_hs;
    logic [KW:0]              w_slot_sum;
    logic [KW:0]              w_slot_wrap;
    logic [KW-1:0]            w_beat_slot;
    logic signed [ACC_W-1:0]  w_delta [L];
    logic signed [ACC_W-1:0]  w_elem;

    // During ACCUM r_x == ic*S, so r_x_slot doubles as the base slot of the current input column.
    assign w_slot_sum  = {1'b0, r_x_slot} + {1'b0, r_kc};
    assign w_slot_wrap = w_slot_sum - K_SUM;
    assign w_beat_slot = (w_slot_sum >= K_SUM) ? w_slot_wrap[KW-1:0] : w_slot_sum[KW-1:0];

    assign w_e_last  = (r_e == ((r_ic == IC_LAST) ? KC_LAST : S_LAST));
    assign w_last_hs = w_hs & w_e_last & (r_ic == IC_LAST);

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_col_valid = 1'b0;
        w_acc       = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            ACCUM: begin
                o_ready = r_live;
                w_acc   = i_valid & r_live;
                if (w_acc && (r_kc == KC_LAST))
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                o_col_valid = 1'b1;
                w_hs        = i_col_ready;
                if (w_hs && w_e_last)
                    w_state_nxt = ACCUM;
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Several (i,k) pairs land on the same output row when S < K; fold them before the ring add.
    always_comb begin
        for (int y = 0; y < L; y++)
            w_delta[y] = '0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++)
                w_delta[i*S+k] = w_delta[i*S+k] + ACC_W'($signed(i_prod_col[(i*K+k)*PW +: PW]));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ACCUM;
            r_live   <= 1'b0;
            r_kc     <= '0;
            r_ic     <= '0;
            r_x      <= '0;
            r_x_slot <= '0;
            r_e      <= '0;
            r_done   <= 1'b0;
            for (int s = 0; s < K; s++)
                for (int y = 0; y < L; y++)
                    r_ring[s][y] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            r_done  <= w_last_hs;
            if (w_acc)
                r_kc <= (r_kc == KC_LAST) ? '0 : r_kc + KW'(1);
            if (w_hs) begin
                if (w_e_last) begin
                    r_e <= '0;
                    if (r_ic == IC_LAST) begin
                        r_ic     <= '0;
                        r_x      <= '0;
                        r_x_slot <= '0;
                    end else begin
                        r_ic     <= r_ic + NW'(1);
                        r_x      <= r_x + 8'd1;
                        r_x_slot <= (r_x_slot == KC_LAST) ? '0 : r_x_slot + KW'(1);
                    end
                end else begin
                    r_e      <= r_e + KW'(1);
                    r_x      <= r_x + 8'd1;
                    r_x_slot <= (r_x_slot == KC_LAST) ? '0 : r_x_slot + KW'(1);
                end
            end
            for (int s = 0; s < K; s++)
                for (int y = 0; y < L; y++) begin
                    if (w_acc && (s == int'(w_beat_slot)))
                        r_ring[s][y] <= r_ring[s][y] + w_delta[y];
                    else if (w_hs && (s == int'(r_x_slot)))
                        r_ring[s][y] <= '0;
                end
        end
    end

    always_comb begin
        o_col  = '0;
        w_elem = '0;
        for (int y = 0; y < L; y++) begin
            w_elem = r_ring[r_x_slot][y];
`ifdef DECONV_OVL_RELU_EN
            if (w_elem[ACC_W-1])
                w_elem = '0;
`endif
            o_col[y*ACC_W +: ACC_W] = o_col_valid ? w_elem : '0;
        end
    end

    assign o_col_idx   = o_col_valid ? r_x : 8'd0;
    assign o_last_col  = o_col_valid & (r_x == X_LAST);
    assign o_chnl_done = r_done;

endmodule

// File: tb/tb_deconv_overlap_add.sv
// Directed bench for deconv_overlap_add at N=8, K=5, S=2 (L=19) with hand-computed expectations.
module tb_deconv_overlap_add;
    localparam int BW  = 8;
    localparam int K   = 5;
    localparam int N   = 8;
    localparam int S   = 2;
    localparam int ACC = 20;
    localparam int L   = 19;
    localparam int PW  = 2*BW;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic                  i_valid = 1'b0;
    logic                  o_ready;
    logic [PW*K*N-1:0]     i_prod_col = '0;
    logic                  o_col_valid;
    logic                  i_col_ready = 1'b0;
    logic [ACC*L-1:0]      o_col;
    logic [7:0]            o_col_idx;
    logic                  o_last_col;
    logic                  o_chnl_done;

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_last = 0;
    int n_cols = 0;
    logic [ACC*L-1:0] cols [L];
    logic [ACC*L-1:0] ref1 [L];
    logic [ACC*L-1:0] snap;

    deconv_overlap_add #(
        .BIT_WIDTH(BW), .NO_COL_KERNEL(K), .NO_COL_INPUT_FEATURE(N), .STRIDE(S), .ACC_W(ACC)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_prod_col(i_prod_col), .o_col_valid(o_col_valid), .i_col_ready(i_col_ready),
        .o_col(o_col), .o_col_idx(o_col_idx), .o_last_col(o_last_col), .o_chnl_done(o_chnl_done)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk)
        if (o_chnl_done === 1'b1) n_done++;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_col(input string tag, input logic [ACC*L-1:0] obs, input logic [ACC*L-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [ACC-1:0] el(input logic [ACC*L-1:0] c, input int y);
        return c[y*ACC +: ACC];
    endfunction

    function automatic int colsum(input logic [ACC*L-1:0] c);
        int s = 0;
        for (int y = 0; y < L; y++) s += int'(el(c, y));
        return s;
    endfunction

    function automatic int nonzero();
        int n = 0;
        for (int x = 0; x < L; x++)
            for (int y = 0; y < L; y++)
                if (el(cols[x], y) != 0) n++;
        return n;
    endfunction

    // mode 0: all +1, mode 1: single 100 at (ic3,kc2,i1,k4), mode 2: all -5
    function automatic logic [PW*K*N-1:0] mkvec(input int mode, input int ic, input int kc);
        logic [PW*K*N-1:0] v = '0;
        for (int j = 0; j < K*N; j++) begin
            if (mode == 0) v[j*PW +: PW] = 16'sd1;
            if (mode == 2) v[j*PW +: PW] = -16'sd5;
        end
        if (mode == 1 && ic == 3 && kc == 2) v[(1*K+4)*PW +: PW] = 16'd100;
        return v;
    endfunction

    task automatic send_beat(input logic [PW*K*N-1:0] v);
        i_prod_col = v;
        i_valid    = 1'b1;
        for (int c = 0; c < 60 && o_ready !== 1'b1; c++) @(negedge i_clk);
        chk("beat_ready", o_ready, 1);
        @(negedge i_clk);
    endtask

    task automatic get_col(input int x);
        for (int c = 0; c < 60 && o_col_valid !== 1'b1; c++) @(negedge i_clk);
        chk("col_valid", o_col_valid, 1);
        chk("col_idx", o_col_idx, x);
        chk("last_col", o_last_col, (x == L-1) ? 1 : 0);
        if (o_last_col === 1'b1) n_last++;
        cols[x] = o_col;
        n_cols++;
        i_col_ready = 1'b1;
        @(negedge i_clk);
        i_col_ready = 1'b0;
    endtask

    task automatic do_ic(input int mode, input int ic);
        for (int kc = 0; kc < K; kc++) send_beat(mkvec(mode, ic, kc));
        for (int e = 0; e < ((ic < N-1) ? S : K); e++) get_col(ic*S + e);
    endtask

    task automatic run_channel(input int mode);
        for (int ic = 0; ic < N; ic++) do_ic(mode, ic);
        i_valid = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge i_clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_col_valid", o_col_valid, 0);
        chk_col("rst_col", o_col, '0);
        chk("rst_idx", o_col_idx, 0);
        chk("rst_last", o_last_col, 0);
        chk("rst_done", o_chnl_done, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_rst_ready", o_ready, 1);

        // Test 1: all products +1
        n_cols = 0; n_last = 0; n_done = 0;
        run_channel(0);
        chk("t1_cols", n_cols, 19);
        chk("t1_last", n_last, 1);
        chk("t1_done", n_done, 1);
        chk("t1_c0r0", el(cols[0], 0), 1);
        chk("t1_c4r4", el(cols[4], 4), 9);
        chk("t1_c4r0", el(cols[4], 0), 3);
        chk("t1_c9r9", el(cols[9], 9), 4);
        chk("t1_c18r18", el(cols[18], 18), 1);
        chk("t1_c4sum", colsum(cols[4]), 120);
        chk("t1_c18sum", colsum(cols[18]), 40);
        for (int x = 0; x < L; x++) ref1[x] = cols[x];

        // Test 3: consumer stalls at the first drain
        for (int kc = 0; kc < K; kc++) send_beat(mkvec(0, 0, kc));
        for (int c = 0; c < 60 && o_col_valid !== 1'b1; c++) @(negedge i_clk);
        snap = o_col;
        chk("t3_row0", el(snap, 0), 1);
        repeat (10) begin
            @(negedge i_clk);
            chk("t3_valid", o_col_valid, 1);
            chk("t3_idx", o_col_idx, 0);
            chk_col("t3_stable", o_col, snap);
            chk("t3_ready", o_ready, 0);
        end
        get_col(0);
        get_col(1);
        chk("t3_ready_after", o_ready, 1);
        for (int ic = 1; ic < N; ic++) do_ic(0, ic);
        i_valid = 1'b0;
        @(negedge i_clk);

        // Test 2: single product
        run_channel(1);
        chk("t2_c8r6", el(cols[8], 6), 100);
        chk("t2_nonzero", nonzero(), 1);

        // Test 4: all products -5
        run_channel(2);
`ifdef DECONV_OVL_RELU_EN
        chk("t4_c4r4", el(cols[4], 4), 0);
        chk("t4_c0r0", el(cols[0], 0), 0);
        chk("t4_nonzero", nonzero(), 0);
`else
        chk("t4_c4r4", el(cols[4], 4), -45);
        chk("t4_c0r0", el(cols[0], 0), -5);
        chk("t4_c18sum", colsum(cols[18]), -200);
`endif

        // Test 5: reset in the middle of the ic=4 drain
        n_done = 0;
        for (int ic = 0; ic < 4; ic++) do_ic(0, ic);
        for (int kc = 0; kc < K; kc++) send_beat(mkvec(0, 4, kc));
        i_valid = 1'b0;
        get_col(8);
        i_rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", o_col_valid, 0);
        chk("t5_rst_ready", o_ready, 0);
        chk_col("t5_rst_col", o_col, '0);
        chk("t5_rst_idx", o_col_idx, 0);
        chk("t5_rst_last", o_last_col, 0);
        repeat (2) @(negedge i_clk);
        chk("t5_rst_done", o_chnl_done, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("t5_ready", o_ready, 1);
        run_channel(0);
        for (int x = 0; x < L; x++) chk_col("t5_match", cols[x], ref1[x]);
        chk("t5_done", n_done, 1);

        // Test 6: two channels back to back, i_valid held high
        n_done = 0; n_cols = 0;
        for (int ic = 0; ic < N; ic++) do_ic(0, ic);
        for (int x = 0; x < L; x++) chk_col("t6_ch1", cols[x], ref1[x]);
        for (int ic = 0; ic < N; ic++) do_ic(0, ic);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        for (int x = 0; x < L; x++) chk_col("t6_ch2", cols[x], ref1[x]);
        chk("t6_cols", n_cols, 38);
        chk("t6_done", n_done, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
